uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit and parity_odd port are enabled by defining UART_TX_PARITY_EN.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BAUD_W = ($clog2(CLKS_PER_BIT) > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q,  baud_d;
    logic [BIT_W-1:0]       bit_q,   bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q,    tx_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
    logic                   baud_wrap_s;
`ifdef UART_TX_PARITY_EN
    logic                   par_q,   par_d;
`endif

    assign baud_wrap_s = (baud_q == BAUD_LAST);

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= BAUD_ZERO;
            bit_q   <= {BIT_W{1'b0}};
            shift_q <= {DATA_BITS{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; tx_d is the line level for the coming cycle so tx stays a flop output
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                baud_d = BAUD_ZERO;
                bit_d  = {BIT_W{1'b0}};
                if (tx_start) begin
                    state_d = START;
                    shift_d = data_in;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data_in) ^ parity_odd;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_wrap_s) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = {BIT_W{1'b0}};
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_wrap_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (baud_wrap_s) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = {BIT_W{1'b0}};
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (baud_wrap_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = {BIT_W{1'b0}};
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                // Unreachable encodings recover to a quiet idle line
                state_d = IDLE;
                baud_d  = BAUD_ZERO;
                bit_d   = {BIT_W{1'b0}};
                shift_d = {DATA_BITS{1'b0}};
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: 8-bit/1-stop instance A and 7-bit/2-stop instance B.
// Stimulus pushes expected frames; a monitor captures tx while busy and compares at each tx_done.
module tb_uart_tx_param;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct packed {
        logic [8:0] data;
        logic       par;
        logic [3:0] dbits;
        logic [1:0] sbits;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, podd_a, tx_a, busy_a, done_a;
    logic [7:0] data_a;
    logic       start_b, podd_b, tx_b, busy_b, done_b;
    logic [6:0] data_b;

    exp_t q0[$];
    exp_t q1[$];
    logic smp [2][256];
    int   nsmp [2] = '{0, 0};
    logic done_prev [2] = '{1'b0, 1'b0};
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_start(start_a), .data_in(data_a),
`ifdef UART_TX_PARITY_EN
        .parity_odd(podd_a),
`endif
        .tx(tx_a), .busy(busy_a), .tx_done(done_a)
    );

    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_start(start_b), .data_in(data_b),
`ifdef UART_TX_PARITY_EN
        .parity_odd(podd_b),
`endif
        .tx(tx_b), .busy(busy_b), .tx_done(done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic fail_now(input string nm);
        checks++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic exp_bit(input exp_t e, input int j);
        if (j == 0) return 1'b0;
        if (j <= int'(e.dbits)) return e.data[j-1];
        if (P == 1 && j == int'(e.dbits) + 1) return e.par;
        return 1'b1;
    endfunction

    task automatic frame_done(input int k);
        exp_t e;
        int   nb, bad, first;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            fail_now($sformatf("unexpected_tx_done[%0d]", k));
            return;
        end
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        nb = 1 + int'(e.dbits) + P + int'(e.sbits);
        chk($sformatf("frame_len[%0d] data=%0h", k, e.data), nsmp[k], nb * CPB);
        bad = 0;
        first = -1;
        for (int i = 0; i < nsmp[k] && i < 256; i++) begin
            if (smp[k][i] !== exp_bit(e, i / CPB)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        chk($sformatf("frame_bits[%0d] data=%0h first_bad_cycle=%0d bad_count", k, e.data, first), bad, 0);
    endtask

    // Monitor: record tx while busy, compare on tx_done, and confirm tx_done is one cycle wide
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                nsmp[0] = 0;
                nsmp[1] = 0;
                done_prev[0] = 1'b0;
                done_prev[1] = 1'b0;
            end else begin
                if (done_prev[0]) chk("done_pulse_a", done_a, 0);
                if (done_prev[1]) chk("done_pulse_b", done_b, 0);
                if (done_a) begin frame_done(0); nsmp[0] = 0; end
                if (done_b) begin frame_done(1); nsmp[1] = 0; end
                if (busy_a && nsmp[0] < 256) begin smp[0][nsmp[0]] = tx_a; nsmp[0]++; end
                if (busy_b && nsmp[1] < 256) begin smp[1][nsmp[1]] = tx_b; nsmp[1]++; end
                done_prev[0] = done_a;
                done_prev[1] = done_b;
            end
        end
    end

    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while (busy_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy_a) fail_now("timeout_wait_idle_a");
    endtask

    task automatic push_a(input logic [7:0] d, input logic par);
        exp_t e;
        e.data  = {1'b0, d};
        e.par   = par;
        e.dbits = 4'd8;
        e.sbits = 2'd1;
        q0.push_back(e);
    endtask

    // par_even is the hand-computed XOR of d
    task automatic send_a(input logic [7:0] d, input logic po, input logic par_even);
        wait_idle_a();
        start_a = 1'b1;
        data_a  = d;
        podd_a  = po;
        @(posedge clk);
        push_a(d, par_even ^ po);
        @(negedge clk);
        start_a = 1'b0;
        data_a  = ~d;
        podd_a  = ~po;
    endtask

    typedef struct packed { logic [7:0] d; logic po; logic pe; } vec_t;
    vec_t vecs [5];

    initial begin
        int   n;
        int   seen;
        exp_t eb;
        rst = 1'b1;
        start_a = 1'b0; data_a = 8'h00; podd_a = 1'b0;
        start_b = 1'b0; data_b = 7'h00; podd_b = 1'b0;
        vecs[0] = '{d: 8'h55, po: 1'b0, pe: 1'b0};
        vecs[1] = '{d: 8'h07, po: 1'b0, pe: 1'b1};
        vecs[2] = '{d: 8'h07, po: 1'b1, pe: 1'b1};
        vecs[3] = '{d: 8'h00, po: 1'b0, pe: 1'b0};
        vecs[4] = '{d: 8'hFF, po: 1'b1, pe: 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_tx_a", tx_a, 1);
        chk("reset_busy_a", busy_a, 0);
        chk("reset_done_a", done_a, 0);
        chk("reset_tx_b", tx_b, 1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) send_a(vecs[i].d, vecs[i].po, vecs[i].pe);

        // tx_start with new data 40 cycles into a frame must be ignored
        send_a(8'hA3, 1'b0, 1'b0);
        repeat (39) @(negedge clk);
        start_a = 1'b1;
        data_a  = 8'hFF;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle_a();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_a) seen++;
        end
        chk("no_second_frame_busy_cycles", seen, 0);

        // tx_start held through tx_done: next frame starts right after the tx_done cycle
        wait_idle_a();
        start_a = 1'b1;
        data_a  = 8'h96;
        podd_a  = 1'b0;
        @(posedge clk);
        push_a(8'h96, 1'b0);
        @(negedge clk);
        data_a = 8'h3C;
        push_a(8'h3C, 1'b0);
        n = 0;
        while (!done_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) fail_now("timeout_b2b_done");
        @(negedge clk);
        chk("b2b_start_busy", busy_a, 1);
        chk("b2b_start_tx", tx_a, 0);
        start_a = 1'b0;
        data_a  = 8'h00;

        // Reset 70 cycles into a frame: outputs go idle asynchronously, no tx_done
        send_a(8'h5A, 1'b0, 1'b0);
        repeat (69) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_tx", tx_a, 1);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_done", done_a, 0);
        void'(q0.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_a(8'h01, 1'b0, 1'b1);

        // 7 data bits, 2 stop bits
        @(negedge clk);
        start_b = 1'b1;
        data_b  = 7'h41;
        podd_b  = 1'b0;
        @(posedge clk);
        eb.data = 9'h041; eb.par = 1'b0; eb.dbits = 4'd7; eb.sbits = 2'd2;
        q1.push_back(eb);
        @(negedge clk);
        start_b = 1'b0;
        data_b  = 7'h3E;
        n = 0;
        while (busy_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy_b) fail_now("timeout_b_idle");

        wait_idle_a();
        repeat (5) @(negedge clk);
        chk("queue_a_empty", q0.size(), 0);
        chk("queue_b_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
